// File: rtl/tetromino_bag_dispenser.sv
// 7-bag tetromino dispenser: rejection-samples LFSR bits into a bag, queues pieces with preview.
// Optional macro DISPENSER_STATS_EN adds saturating reject/fallback counters.
module tetromino_bag_dispenser #(
    parameter int DEPTH     = 4,
    parameter int MAX_TRIES = 8,
    parameter int WARMUP    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rand_bits,
    output logic        piece_valid,
    input  logic        piece_ready,
    output logic [2:0]  piece_id,
    output logic [2:0]  preview_id,
    output logic [2:0]  bag_remaining
`ifdef DISPENSER_STATS_EN
    ,
    output logic [15:0] reject_count,
    output logic [15:0] fallback_count
`endif
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_WARMUP, S_DRAW, S_FULL} state_e;

    state_e          state_q, state_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic [TW-1:0]   try_q, try_d;
    logic [6:0]      bag_q, bag_d, bag_clr;
    logic [2:0]      q_q [DEPTH];
    logic [2:0]      q_d [DEPTH];
    logic [CW-1:0]   cnt_q, cnt_d, wr_idx;

    logic       pop, push, accept, reject, fallback, in_draw, s_hit;
    logic [2:0] low_id, push_id;
    logic [7:0] bag_ext;

    assign in_draw  = (state_q == S_DRAW);
    assign pop      = (cnt_q != '0) && piece_ready;
    assign bag_ext  = {bag_q, 1'b0};
    // bag_ext[0] is always 0, so a zero sample is rejected without a special case
    assign s_hit    = bag_ext[rand_bits];
    assign fallback = in_draw && (try_q == TW'(MAX_TRIES));
    assign accept   = in_draw && !fallback && s_hit;
    assign reject   = in_draw && !fallback && !s_hit;
    assign push     = fallback || accept;
    assign push_id  = fallback ? low_id : rand_bits;
    assign wr_idx   = cnt_q - CW'(pop);

    always_comb begin
        low_id = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (bag_q[i]) low_id = 3'(i + 1);
    end

    always_comb begin
        bag_clr = bag_q & ~7'((8'd1 << push_id) >> 1);
        bag_d   = bag_q;
        if (push) bag_d = (bag_clr == 7'h00) ? 7'h7F : bag_clr;
    end

    always_comb begin
        try_d = try_q;
        if (push)        try_d = '0;
        else if (reject) try_d = try_q + TW'(1);
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == S_WARMUP && wcnt_q != 16'(WARMUP)) wcnt_d = wcnt_q + 16'd1;
    end

    // Shift-style queue: entry 0 is the head, entry 1 the preview.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_d[i] = q_q[i];
            if (pop) q_d[i] = (i < DEPTH - 1) ? q_q[i + 1] : 3'd0;
            if (push && (CW'(i) == wr_idx)) q_d[i] = push_id;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_WARMUP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WARMUP: if (wcnt_q == 16'(WARMUP)) state_d = S_DRAW;
            S_DRAW:   if (cnt_d == CW'(DEPTH))   state_d = S_FULL;
            S_FULL:   if (pop)                   state_d = S_DRAW;
            default:  state_d = S_WARMUP;
        endcase
    end

    always_comb begin
        piece_valid   = (cnt_q != '0);
        piece_id      = piece_valid ? q_q[0] : 3'd0;
        preview_id    = (cnt_q >= CW'(2)) ? q_q[1] : 3'd0;
        bag_remaining = 3'd0;
        for (int i = 0; i < 7; i++) bag_remaining = bag_remaining + {2'b00, bag_q[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            try_q  <= '0;
            bag_q  <= 7'h7F;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) q_q[i] <= 3'd0;
        end else begin
            wcnt_q <= wcnt_d;
            try_q  <= try_d;
            bag_q  <= bag_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
        end
    end

`ifdef DISPENSER_STATS_EN
    logic [15:0] rej_q, fb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q <= '0;
            fb_q  <= '0;
        end else begin
            if (reject && rej_q != 16'hFFFF)  rej_q <= rej_q + 16'd1;
            if (fallback && fb_q != 16'hFFFF) fb_q  <= fb_q + 16'd1;
        end
    end

    assign reject_count   = rej_q;
    assign fallback_count = fb_q;
`endif

endmodule
